pattern_blinker: RTL

PATTERN_BLINKER -- requirements
Module: pattern_blinker

---
 rtl/pattern_blinker_pkg.sv | 35 +++
 rtl/pattern_blinker_onehot_decoder.sv | 18 +
 rtl/pattern_blinker.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pattern_blinker_pkg.sv
// Shared types and constants for the pattern blinker: FSM state encoding,
// speed encoding and the tick-duration helper.
package pattern_blinker_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ON,
    OFF,
    FINISH
  } blink_state_t;

  localparam int unsigned SPEED_W = 2;

  // Each speed step halves the ON/OFF durations.
  localparam logic [SPEED_W-1:0] SPEED_X1 = 2'd0;
  localparam logic [SPEED_W-1:0] SPEED_X2 = 2'd1;
  localparam logic [SPEED_W-1:0] SPEED_X4 = 2'd2;
  localparam logic [SPEED_W-1:0] SPEED_X8 = 2'd3;

  // Duration in cycles for a base tick count at a given speed, never below 1.
  function automatic int unsigned scaled_ticks(input int unsigned base,
                                               input logic [SPEED_W-1:0] spd);
    int unsigned t;
    case (spd)
      SPEED_X1: t = base;
      SPEED_X2: t = base >> 1;
      SPEED_X4: t = base >> 2;
      SPEED_X8: t = base >> 3;
      default:  t = base >> 3;
    endcase
    return (t == 0) ? 1 : t;
  endfunction

endpackage

// File: rtl/pattern_blinker_onehot_decoder.sv
// LED index to one-hot drive; indices >= N_LEDS and bits >= N_LEDS stay dark.
module onehot_decoder #(
  parameter int unsigned N_LEDS = 4,
  parameter int unsigned LED_W  = 10,
  localparam int unsigned IDX_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
  input  logic [IDX_W-1:0] i_idx,
  output logic [LED_W-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    for (int unsigned i = 0; i < N_LEDS; i++) begin
      if (i_idx == IDX_W'(i)) o_onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/pattern_blinker.sv
// Plays a sequence of LED indices fetched from an external pattern memory,
// lighting each one for a speed-scaled ON time followed by a dark OFF gap.
module pattern_blinker
  import pattern_blinker_pkg::*;
#(
  parameter int unsigned N_LEDS    = 4,
  parameter int unsigned LED_W     = 10,
  parameter int unsigned MAX_LEN   = 16,
  parameter int unsigned ON_TICKS  = 25_000_000,
  parameter int unsigned OFF_TICKS = 25_000_000,
  localparam int unsigned IDX_W    = (N_LEDS > 1) ? $clog2(N_LEDS) : 1,
  localparam int unsigned LEN_W    = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [LEN_W-1:0]   length,
  input  logic [SPEED_W-1:0] speed,
  input  logic [IDX_W-1:0]   idx_in,
  output logic [LEN_W-1:0]   addr,
  output logic [LED_W-1:0]   led_out,
  output logic               busy,
  output logic               done
);

  localparam int unsigned MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int unsigned CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  blink_state_t       r_state, w_state_nxt;
  logic [LEN_W-1:0]   r_addr, w_addr_nxt;
  logic [LEN_W-1:0]   r_len, w_len_nxt, w_len_clamped;
  logic [SPEED_W-1:0] r_speed, w_speed_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt, w_on_load, w_off_load;
  logic [LED_W-1:0]   r_led, w_led_nxt, w_onehot;
  logic               r_busy, r_done;

  // Counter holds remaining cycles minus one, so a load of 0 gives one cycle.
  assign w_on_load     = CNT_W'(scaled_ticks(ON_TICKS, r_speed) - 1);
  assign w_off_load    = CNT_W'(scaled_ticks(OFF_TICKS, r_speed) - 1);
  assign w_len_clamped = (length > MAX_LEN_L) ? MAX_LEN_L : length;

  onehot_decoder #(
    .N_LEDS (N_LEDS),
    .LED_W  (LED_W)
  ) u_decoder (
    .i_idx    (w_idx_nxt),
    .o_onehot (w_onehot)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_speed <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_led   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_len   <= w_len_nxt;
      r_speed <= w_speed_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_led   <= w_led_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= (w_state_nxt == FINISH);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_len_nxt   = r_len;
    w_speed_nxt = r_speed;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = (r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;

    case (r_state)
      IDLE: begin
        if (start && !abort) begin
          w_len_nxt   = w_len_clamped;
          w_speed_nxt = speed;
          w_addr_nxt  = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = (w_len_clamped == '0) ? FINISH : FETCH;
        end
      end
      FETCH: begin
        w_idx_nxt   = idx_in;
        w_cnt_nxt   = w_on_load;
        w_state_nxt = ON;
      end
      ON: begin
        if (r_cnt == '0) begin
          w_cnt_nxt   = w_off_load;
          w_state_nxt = OFF;
        end
      end
      OFF: begin
        if (r_cnt == '0) begin
          w_cnt_nxt = '0;
          if (r_addr + LEN_W'(1) == r_len) begin
            w_state_nxt = FINISH;
          end else begin
            w_addr_nxt  = r_addr + LEN_W'(1);
            w_state_nxt = FETCH;
          end
        end
      end
      FINISH: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase

    if (abort) begin
      w_state_nxt = IDLE;
      w_addr_nxt  = '0;
      w_cnt_nxt   = '0;
    end

    w_led_nxt = (w_state_nxt == ON) ? w_onehot : '0;
  end

  assign addr    = r_addr;
  assign led_out = r_led;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule
